load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL expose these ports (name, direction, width, meaning); clock and reset come first.
REQ-002 clk, input, 1, single clock; all state updates on the rising edge.
REQ-003 reset, input, 1, asynchronous, active-high.
REQ-004 start, input, 1, request strobe; sampled only in IDLE.
REQ-005 opcode, input, 6, one of LB/LBU/LH/LHU/LW/SB/SH/SW using the shared package encodings.
REQ-006 addr, input, 32, byte address; store_data, input, 32, register value to store.
REQ-007 busy, output, 1, high in ACCESS and DONE.
REQ-008 done, output, 1, one-cycle completion pulse.
REQ-009 load_data, output, 32, extended load result; err, output, 1, qualifies done.
REQ-010 address, output, 32; read, output, 1; write, output, 1; byteenable, output, 4; writedata, output, 32; memory-side bus signals.
REQ-011 waitrequest, input, 1; readdata, input, 32; memory-side bus signals.

Function
REQ-012 FSM states SHALL be IDLE, ACCESS and DONE.
REQ-013 IDLE with start=1 and a supported opcode SHALL register opcode, addr and store_data, then move to ACCESS.
REQ-014 ACCESS SHALL drive read (loads) or write (stores) together with address={addr[31:2],2'b00}, byteenable and writedata, all held stable while waitrequest=1.
REQ-015 In ACCESS, the first cycle with waitrequest=0 SHALL complete the transfer; loads capture readdata that cycle; next state is DONE.
REQ-016 DONE SHALL assert done=1 for exactly one cycle with load_data valid, then return to IDLE; minimum start-to-done latency is 2 cycles.
REQ-017 start outside IDLE SHALL be ignored; a request is never queued.
REQ-018 Store byteenable SHALL be: SB 4'b0001<<addr[1:0]; SH 4'b0011 if addr[1]=0, else 4'b1100; SW 4'b1111.
REQ-019 Store writedata SHALL be: SB store_data[7:0] replicated x4; SH store_data[15:0] replicated x2; SW store_data.
REQ-020 Loads SHALL select the lane addressed by addr[1:0] (byte) or addr[1] (half); LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes the word through.
REQ-021 load_data SHALL hold its last value until the next load completes; stores SHALL leave it unchanged.
REQ-022 An unsupported opcode with start SHALL skip ACCESS, go directly to DONE, and assert err=1 with done.
REQ-023 read and write SHALL never be high in the same cycle, and SHALL be 0 outside ACCESS.

Reset
REQ-024 Asserting reset SHALL force IDLE with busy=0, done=0, err=0, read=0, write=0, byteenable=0, address=0, writedata=0 and load_data=0.
REQ-025 Reset asserted mid-ACCESS SHALL drop read/write immediately (asynchronously), and the aborted access SHALL produce no done pulse.

Configuration
REQ-026 Macro LSU_MISALIGN_ERR_EN defined: an LH/LHU/SH with addr[0]=1, or an LW/SW with addr[1:0]!=0, SHALL perform no bus access and SHALL complete via DONE with err=1.
REQ-027 Macro LSU_MISALIGN_ERR_EN undefined: the low address bits that cause misalignment SHALL be ignored (forced to 0 for lane selection), the access SHALL proceed, and err SHALL be 1 only for unsupported opcodes.

Structure
REQ-028 The opcode constants OPCODE_LB, OPCODE_LBU, OPCODE_LH, OPCODE_LHU, OPCODE_LW, OPCODE_SB, OPCODE_SH and OPCODE_SW, plus the FSM state typedef, SHALL live in package.v.
REQ-029 Lane packing and extraction SHALL be a combinational sub-module, lsu_lane_mux (inputs opcode, addr[1:0], store_data, readdata; outputs byteenable, writedata, load_data_next); the FSM stays in load_store_unit.

Verification
REQ-030 SB: addr=0x1002, store_data=0x000000A5, waitrequest=0 -> write=1, address=0x1000, byteenable=4'b0100, writedata=0xA5A5A5A5; done 2 cycles after start.
REQ-031 LB: addr=0x2003, readdata=0x80112233 -> load_data=0xFFFFFF80; the same access with LBU -> 0x00000080.
REQ-032 LH: addr=0x2002, readdata=0x7FFF8000, waitrequest high for 3 cycles -> read and address held 3 cycles, load_data=0x00007FFF, done on the 5th cycle after start.
REQ-033 SW: addr=0x3001 -> with LSU_MISALIGN_ERR_EN, write never asserts and done=1 with err=1; without it, address=0x3000, byteenable=4'b1111, err=0.
REQ-034 Reset pulse during ACCESS with waitrequest=1 -> read=0 the same cycle, state IDLE, no done pulse; a following LW completes normally.
REQ-035 start asserted during busy, and an unsupported opcode=6'h3F -> the extra start is ignored; the bad opcode gives done with err=1 and no bus access.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: opcode encodings, FSM state
// type, access-size decode and helper predicates used by the FSM and lane mux.
package load_store_unit_pkg;

  localparam int DATA_W = 32;
  localparam int OP_W   = 6;

  localparam logic [OP_W-1:0] OPCODE_LB  = 6'h01;
  localparam logic [OP_W-1:0] OPCODE_LBU = 6'h02;
  localparam logic [OP_W-1:0] OPCODE_LH  = 6'h03;
  localparam logic [OP_W-1:0] OPCODE_LHU = 6'h04;
  localparam logic [OP_W-1:0] OPCODE_LW  = 6'h05;
  localparam logic [OP_W-1:0] OPCODE_SB  = 6'h09;
  localparam logic [OP_W-1:0] OPCODE_SH  = 6'h0A;
  localparam logic [OP_W-1:0] OPCODE_SW  = 6'h0B;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } lsu_state_t;

  typedef enum logic [1:0] {
    SIZE_B    = 2'd0,
    SIZE_H    = 2'd1,
    SIZE_W    = 2'd2,
    SIZE_NONE = 2'd3
  } lsu_size_t;

  function automatic lsu_size_t op_size(input logic [OP_W-1:0] op);
    case (op)
      OPCODE_LB, OPCODE_LBU, OPCODE_SB: op_size = SIZE_B;
      OPCODE_LH, OPCODE_LHU, OPCODE_SH: op_size = SIZE_H;
      OPCODE_LW, OPCODE_SW:             op_size = SIZE_W;
      default:                          op_size = SIZE_NONE;
    endcase
  endfunction

  function automatic logic op_is_load(input logic [OP_W-1:0] op);
    op_is_load = (op == OPCODE_LB) || (op == OPCODE_LBU) || (op == OPCODE_LH) ||
                 (op == OPCODE_LHU) || (op == OPCODE_LW);
  endfunction

  function automatic logic op_is_store(input logic [OP_W-1:0] op);
    op_is_store = (op == OPCODE_SB) || (op == OPCODE_SH) || (op == OPCODE_SW);
  endfunction

  function automatic logic op_supported(input logic [OP_W-1:0] op);
    op_supported = (op_size(op) != SIZE_NONE);
  endfunction

  // Halfwords must sit on an even byte, words on a 4-byte boundary.
  function automatic logic op_misaligned(input logic [OP_W-1:0] op, input logic [1:0] lo);
    case (op_size(op))
      SIZE_H:  op_misaligned = lo[0];
      SIZE_W:  op_misaligned = (lo != 2'b00);
      default: op_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_lane.sv
// Combinational lane packing/extraction for the load/store unit.
// Stores: byte/half replication across the word plus the matching byteenable.
// Loads: select the addressed lane and sign- or zero-extend it. Address bits
// below the access size are ignored, so a misaligned access uses the aligned lane.
module lsu_lane_mux
  import load_store_unit_pkg::*;
(
  input  logic [OP_W-1:0]   opcode,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] store_data,
  input  logic [DATA_W-1:0] readdata,
  output logic [3:0]        byteenable,
  output logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] load_data_next
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  // Pick the addressed byte and halfword out of the read word.
  always_comb begin
    rd_byte = readdata[7:0];
    case (addr)
      2'd0: rd_byte = readdata[7:0];
      2'd1: rd_byte = readdata[15:8];
      2'd2: rd_byte = readdata[23:16];
      2'd3: rd_byte = readdata[31:24];
      default: rd_byte = readdata[7:0];
    endcase
    rd_half = addr[1] ? readdata[31:16] : readdata[15:0];
  end

  // Byte enables and write data depend only on access size; load extension on opcode.
  always_comb begin
    byteenable     = 4'b0000;
    writedata      = '0;
    load_data_next = '0;
    case (op_size(opcode))
      SIZE_B: begin
        byteenable = 4'b0001 << addr;
        writedata  = {4{store_data[7:0]}};
      end
      SIZE_H: begin
        byteenable = addr[1] ? 4'b1100 : 4'b0011;
        writedata  = {2{store_data[15:0]}};
      end
      SIZE_W: begin
        byteenable = 4'b1111;
        writedata  = store_data;
      end
      default: begin
        byteenable = 4'b0000;
        writedata  = '0;
      end
    endcase
    case (opcode)
      OPCODE_LB:  load_data_next = {{24{rd_byte[7]}}, rd_byte};
      OPCODE_LBU: load_data_next = {24'd0, rd_byte};
      OPCODE_LH:  load_data_next = {{16{rd_half[15]}}, rd_half};
      OPCODE_LHU: load_data_next = {16'd0, rd_half};
      OPCODE_LW:  load_data_next = readdata;
      default:    load_data_next = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one LB/LBU/LH/LHU/LW/SB/SH/SW request at a time and
// runs it as a single Avalon-style transfer (read/write held while waitrequest).
// Optional build macro LSU_MISALIGN_ERR_EN: misaligned halfword/word accesses
// skip the bus and complete with err=1. Without it, misalignment is ignored.
module load_store_unit
  import load_store_unit_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [OP_W-1:0]   opcode,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] store_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] load_data,
  output logic              err,
  output logic [DATA_W-1:0] address,
  output logic              read,
  output logic              write,
  output logic [3:0]        byteenable,
  output logic [DATA_W-1:0] writedata,
  input  logic              waitrequest,
  input  logic [DATA_W-1:0] readdata
);

  lsu_state_t        state;
  lsu_state_t        state_next;
  logic [OP_W-1:0]   opcode_r;
  logic [DATA_W-1:0] addr_r;
  logic [DATA_W-1:0] store_data_r;
  logic [DATA_W-1:0] load_data_r;
  logic              err_r;
  logic              bad_req;
  logic [3:0]        be_mux;
  logic [DATA_W-1:0] wd_mux;
  logic [DATA_W-1:0] ld_next;

  lsu_lane_mux u_lane (
    .opcode         (opcode_r),
    .addr           (addr_r[1:0]),
    .store_data     (store_data_r),
    .readdata       (readdata),
    .byteenable     (be_mux),
    .writedata      (wd_mux),
    .load_data_next (ld_next)
  );

  // Classify the incoming request: requests that cannot go on the bus finish with err.
  always_comb begin
    bad_req = !op_supported(opcode);
`ifdef LSU_MISALIGN_ERR_EN
    bad_req = bad_req || op_misaligned(opcode, addr[1:0]);
`else
    bad_req = bad_req;
`endif
  end

  // State register; reset aborts any transfer in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic: start only honoured in IDLE, bus transfer ends on first waitrequest=0.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = bad_req ? DONE : ACCESS;
      ACCESS:  if (!waitrequest) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request capture in IDLE and load result capture on the completing bus cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opcode_r     <= '0;
      addr_r       <= '0;
      store_data_r <= '0;
      load_data_r  <= '0;
      err_r        <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        opcode_r     <= opcode;
        addr_r       <= addr;
        store_data_r <= store_data;
        err_r        <= bad_req;
      end
      if (state == ACCESS && !waitrequest && op_is_load(opcode_r))
        load_data_r <= ld_next;
    end
  end

  // Outputs decoded from state so read/write drop the moment reset asserts.
  always_comb begin
    busy       = (state == ACCESS) || (state == DONE);
    done       = (state == DONE);
    err        = (state == DONE) && err_r;
    read       = (state == ACCESS) && op_is_load(opcode_r);
    write      = (state == ACCESS) && op_is_store(opcode_r);
    byteenable = (state == ACCESS) ? be_mux : 4'b0000;
    address    = {addr_r[DATA_W-1:2], 2'b00};
    writedata  = wd_mux;
    load_data  = load_data_r;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus a randomized
// sequence checked against a behavioural model of the load/store rules.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, waitrequest;
  logic [5:0]  opcode;
  logic [31:0] addr, store_data, readdata;
  logic        busy, done, err, read, write;
  logic [31:0] load_data, address, writedata;
  logic [3:0]  byteenable;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_ld;

  // results of one transaction
  int          o_lat, o_acc;
  logic        o_err, o_rd, o_wr, o_stable, o_overlap, o_extra_done, o_busy_after;
  logic [31:0] o_addr, o_wd, o_ld;
  logic [3:0]  o_be;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode), .addr(addr),
    .store_data(store_data), .busy(busy), .done(done), .load_data(load_data),
    .err(err), .address(address), .read(read), .write(write),
    .byteenable(byteenable), .writedata(writedata), .waitrequest(waitrequest),
    .readdata(readdata)
  );

  // ---------------- reference model ----------------
  function automatic bit m_load(input logic [5:0] op);
    return op == OPCODE_LB || op == OPCODE_LBU || op == OPCODE_LH || op == OPCODE_LHU || op == OPCODE_LW;
  endfunction
  function automatic bit m_store(input logic [5:0] op);
    return op == OPCODE_SB || op == OPCODE_SH || op == OPCODE_SW;
  endfunction
  function automatic bit m_bad(input logic [5:0] op, input logic [31:0] a);
    bit mis;
    mis = 0;
    if (op == OPCODE_LH || op == OPCODE_LHU || op == OPCODE_SH) mis = (a % 2) != 0;
    if (op == OPCODE_LW || op == OPCODE_SW) mis = (a % 4) != 0;
`ifdef LSU_MISALIGN_ERR_EN
    return !(m_load(op) || m_store(op)) || mis;
`else
    return !(m_load(op) || m_store(op)) || (mis && 1'b0);
`endif
  endfunction
  function automatic logic [31:0] m_ld(input logic [5:0] op, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v;
    v = rd;
    if (op == OPCODE_LB || op == OPCODE_LBU) begin
      v = (rd >> (8 * (a % 4))) & 32'hFF;
      if (op == OPCODE_LB && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (op == OPCODE_LH || op == OPCODE_LHU) begin
      v = (rd >> (16 * ((a / 2) % 2))) & 32'hFFFF;
      if (op == OPCODE_LH && v >= 32768) v = v + 32'hFFFF_0000;
    end
    return v;
  endfunction
  function automatic logic [3:0] m_be(input logic [5:0] op, input logic [31:0] a);
    if (op == OPCODE_SB) return 4'(1 << (a % 4));
    if (op == OPCODE_SH) return ((a / 2) % 2) ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction
  function automatic logic [31:0] m_wd(input logic [5:0] op, input logic [31:0] sd);
    if (op == OPCODE_SB) return (sd & 32'hFF) * 32'h0101_0101;
    if (op == OPCODE_SH) return (sd & 32'hFFFF) * 32'h0001_0001;
    return sd;
  endfunction

  // ---------------- transaction driver / monitor ----------------
  task automatic do_txn(input logic [5:0] op, input logic [31:0] a, input logic [31:0] sd,
                        input logic [31:0] rd, input int nwait, input bit hold_start);
    o_lat = -1; o_acc = 0; o_err = 0; o_rd = 0; o_wr = 0; o_stable = 1; o_overlap = 0;
    o_addr = 0; o_be = 0; o_wd = 0; o_ld = 0;
    @(negedge clk);
    start = 1; opcode = op; addr = a; store_data = sd; readdata = rd; waitrequest = (nwait > 0);
    @(posedge clk);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (hold_start) begin start = 1; opcode = OPCODE_SW; addr = $urandom; end
      else start = 0;
      if (read && write) o_overlap = 1;
      if (read || write) begin
        o_acc++;
        if (o_acc == 1) begin
          o_rd = read; o_wr = write; o_addr = address; o_be = byteenable; o_wd = writedata;
        end else if (read !== o_rd || write !== o_wr || address !== o_addr ||
                     byteenable !== o_be || writedata !== o_wd) o_stable = 0;
        waitrequest = (o_acc <= nwait);
      end
      if (done) begin
        o_lat = cyc; o_err = err; o_ld = load_data; start = 0;
        break;
      end
    end
    @(negedge clk);
    start = 0; waitrequest = 0;
    o_extra_done = done; o_busy_after = busy;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset = 1;
    repeat (2) @(negedge clk);
    checks++;
    if ({read, write, byteenable, address, writedata} !== 70'd0) begin
      errors++; $display("FAIL reset_bus got r%b w%b be%b a%h wd%h exp zeros", read, write, byteenable, address, writedata);
    end
    checks++;
    if ({busy, done, err} !== 3'b000) begin
      errors++; $display("FAIL reset_ctl got %b exp 000", {busy, done, err});
    end
    checks++;
    if (load_data !== 32'd0) begin
      errors++; $display("FAIL reset_ld got %h exp 0", load_data);
    end
    reset = 0;
    model_ld = 0;
  endtask

  task automatic test_sb;
    do_txn(OPCODE_SB, 32'h1002, 32'h0000_00A5, 32'h0, 0, 0);
    checks++;
    if ({o_wr, o_rd} !== 2'b10) begin errors++; $display("FAIL sb_dir got w%b r%b exp w1 r0", o_wr, o_rd); end
    checks++;
    if (o_addr !== 32'h1000) begin errors++; $display("FAIL sb_addr got %h exp 00001000", o_addr); end
    checks++;
    if (o_be !== 4'b0100) begin errors++; $display("FAIL sb_be got %b exp 0100", o_be); end
    checks++;
    if (o_wd !== 32'hA5A5A5A5) begin errors++; $display("FAIL sb_wd got %h exp a5a5a5a5", o_wd); end
    checks++;
    if (o_lat !== 2 || o_err !== 1'b0) begin errors++; $display("FAIL sb_done got lat %0d err %b exp lat 2 err 0", o_lat, o_err); end
    checks++;
    if (o_ld !== model_ld) begin errors++; $display("FAIL sb_ld_kept got %h exp %h", o_ld, model_ld); end
    checks++;
    if (o_extra_done !== 1'b0 || o_busy_after !== 1'b0) begin
      errors++; $display("FAIL sb_pulse got done %b busy %b exp 0 0", o_extra_done, o_busy_after);
    end
  endtask

  task automatic test_lb_lbu;
    do_txn(OPCODE_LB, 32'h2003, 32'h0, 32'h80112233, 0, 0);
    model_ld = 32'hFFFF_FF80;
    checks++;
    if (o_ld !== model_ld || o_lat !== 2 || o_rd !== 1'b1) begin
      errors++; $display("FAIL lb got ld %h lat %0d rd %b exp ld ffffff80 lat 2 rd 1", o_ld, o_lat, o_rd);
    end
    do_txn(OPCODE_LBU, 32'h2003, 32'h0, 32'h80112233, 0, 0);
    model_ld = 32'h0000_0080;
    checks++;
    if (o_ld !== model_ld || o_lat !== 2) begin
      errors++; $display("FAIL lbu got ld %h lat %0d exp ld 00000080 lat 2", o_ld, o_lat);
    end
  endtask

  task automatic test_lh_wait;
    do_txn(OPCODE_LH, 32'h2002, 32'h0, 32'h7FFF8000, 3, 0);
    model_ld = 32'h0000_7FFF;
    checks++;
    if (o_acc !== 4 || o_stable !== 1'b1 || o_addr !== 32'h2000) begin
      errors++; $display("FAIL lh_hold got acc %0d stable %b addr %h exp acc 4 stable 1 addr 00002000", o_acc, o_stable, o_addr);
    end
    checks++;
    if (o_ld !== model_ld || o_lat !== 5) begin
      errors++; $display("FAIL lh_wait got ld %h lat %0d exp ld 00007fff lat 5", o_ld, o_lat);
    end
  endtask

  task automatic test_sw_misalign;
    logic [31:0] sd;
    sd = $urandom;
    do_txn(OPCODE_SW, 32'h3001, sd, 32'h0, 0, 0);
`ifdef LSU_MISALIGN_ERR_EN
    checks++;
    if (o_acc !== 0 || o_err !== 1'b1 || o_lat !== 1) begin
      errors++; $display("FAIL sw_mis got acc %0d err %b lat %0d exp acc 0 err 1 lat 1", o_acc, o_err, o_lat);
    end
`else
    checks++;
    if (o_addr !== 32'h3000 || o_be !== 4'b1111 || o_wd !== sd || o_wr !== 1'b1) begin
      errors++; $display("FAIL sw_mis got addr %h be %b wd %h w %b exp 00003000 1111 %h 1", o_addr, o_be, o_wd, o_wr, sd);
    end
    checks++;
    if (o_err !== 1'b0 || o_lat !== 2) begin
      errors++; $display("FAIL sw_mis_done got err %b lat %0d exp err 0 lat 2", o_err, o_lat);
    end
`endif
  endtask

  task automatic test_reset_mid_access;
    logic [31:0] rd;
    bit seen_done;
    @(negedge clk);
    start = 1; opcode = OPCODE_LW; addr = 32'h4000; waitrequest = 1; readdata = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    start = 0;
    checks++;
    if (read !== 1'b1) begin errors++; $display("FAIL rst_mid_pre got read %b exp 1", read); end
    #1 reset = 1;
    #1;
    checks++;
    if ({read, write, busy} !== 3'b000) begin
      errors++; $display("FAIL rst_mid_async got r%b w%b busy%b exp 000", read, write, busy);
    end
    @(negedge clk);
    reset = 0;
    model_ld = 0;
    seen_done = 0;
    waitrequest = 0;
    repeat (5) begin
      @(negedge clk);
      if (done || read || write) seen_done = 1;
    end
    checks++;
    if (seen_done !== 1'b0) begin errors++; $display("FAIL rst_mid_nodone got activity %b exp 0", seen_done); end
    rd = $urandom;
    do_txn(OPCODE_LW, 32'h4004, 32'h0, rd, 1, 0);
    model_ld = rd;
    checks++;
    if (o_ld !== model_ld || o_lat !== 3 || o_err !== 1'b0) begin
      errors++; $display("FAIL rst_mid_lw got ld %h lat %0d err %b exp ld %h lat 3 err 0", o_ld, o_lat, o_err, rd);
    end
  endtask

  task automatic test_busy_and_bad_opcode;
    do_txn(OPCODE_LHU, 32'h5002, 32'hDEAD_BEEF, 32'hABCD_1234, 2, 1);
    model_ld = 32'h0000_ABCD;
    checks++;
    if (o_wr !== 1'b0 || o_overlap !== 1'b0 || o_acc !== 3 || o_busy_after !== 1'b0) begin
      errors++; $display("FAIL busy_start got w %b ovl %b acc %0d busy_after %b exp 0 0 3 0", o_wr, o_overlap, o_acc, o_busy_after);
    end
    checks++;
    if (o_ld !== model_ld || o_lat !== 4) begin
      errors++; $display("FAIL busy_lhu got ld %h lat %0d exp ld 0000abcd lat 4", o_ld, o_lat);
    end
    do_txn(6'h3F, 32'h6000, 32'h1111_1111, 32'h2222_2222, 0, 0);
    checks++;
    if (o_err !== 1'b1 || o_lat !== 1 || o_acc !== 0) begin
      errors++; $display("FAIL bad_op got err %b lat %0d acc %0d exp err 1 lat 1 acc 0", o_err, o_lat, o_acc);
    end
    checks++;
    if (o_ld !== model_ld) begin errors++; $display("FAIL bad_op_ld got %h exp %h", o_ld, model_ld); end
  endtask

  task automatic test_random;
    logic [5:0] ops [11];
    logic [5:0] op;
    logic [31:0] a, sd, rd;
    int nw;
    bit bad;
    ops = '{OPCODE_LB, OPCODE_LBU, OPCODE_LH, OPCODE_LHU, OPCODE_LW,
            OPCODE_SB, OPCODE_SH, OPCODE_SW, 6'h00, 6'h3F, 6'h20};
    for (int i = 0; i < 60; i++) begin
      op = ops[$urandom_range(0, 10)];
      a = $urandom; sd = $urandom; rd = $urandom;
      nw = $urandom_range(0, 3);
      bad = m_bad(op, a);
      do_txn(op, a, sd, rd, nw, 1'($urandom_range(0, 1)));
      if (!bad && m_load(op)) model_ld = m_ld(op, a, rd);
      checks++;
      if (o_lat !== (bad ? 1 : nw + 2) || o_err !== bad) begin
        errors++; $display("FAIL rnd_done[%0d] op %h a %h got lat %0d err %b exp lat %0d err %b",
                           i, op, a, o_lat, o_err, bad ? 1 : nw + 2, bad);
      end
      checks++;
      if (o_acc !== (bad ? 0 : nw + 1) || o_overlap !== 1'b0 || o_stable !== 1'b1) begin
        errors++; $display("FAIL rnd_bus[%0d] op %h got acc %0d ovl %b stable %b exp acc %0d ovl 0 stable 1",
                           i, op, o_acc, o_overlap, o_stable, bad ? 0 : nw + 1);
      end
      if (!bad) begin
        checks++;
        if (o_rd !== m_load(op) || o_wr !== m_store(op) || o_addr !== (a & 32'hFFFF_FFFC)) begin
          errors++; $display("FAIL rnd_cmd[%0d] op %h got r%b w%b addr %h exp r%b w%b addr %h",
                             i, op, o_rd, o_wr, o_addr, m_load(op), m_store(op), a & 32'hFFFF_FFFC);
        end
      end
      if (!bad && m_store(op)) begin
        checks++;
        if (o_be !== m_be(op, a) || o_wd !== m_wd(op, sd)) begin
          errors++; $display("FAIL rnd_store[%0d] op %h a %h got be %b wd %h exp be %b wd %h",
                             i, op, a, o_be, o_wd, m_be(op, a), m_wd(op, sd));
        end
      end
      checks++;
      if (o_ld !== model_ld) begin
        errors++; $display("FAIL rnd_ld[%0d] op %h a %h rd %h got %h exp %h", i, op, a, rd, o_ld, model_ld);
      end
      checks++;
      if (o_extra_done !== 1'b0 || o_busy_after !== 1'b0) begin
        errors++; $display("FAIL rnd_pulse[%0d] got done %b busy %b exp 0 0", i, o_extra_done, o_busy_after);
      end
    end
  endtask

  initial begin
    reset = 1; start = 0; opcode = 0; addr = 0; store_data = 0;
    readdata = 0; waitrequest = 0; model_ld = 0;
    test_reset;
    test_sb;
    test_lb_lbu;
    test_lh_wait;
    test_sw_misalign;
    test_reset_mid_access;
    test_busy_and_bad_opcode;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
